// File: rtl/disp_arbiter.sv
// disp_arbiter
//   Shares the six-digit seven-segment display between NREQ value sources.
//   Each round-robin turn snapshots one source, saturates it to 999999,
//   converts it to BCD with a W-step shift-and-add-3 sequence, then holds
//   the digits for DWELL cycles before arbitrating again.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   req        per-source request (level)
//   val        flat value bus, source i at [i*W +: W]
//   grant      one-hot pulse marking the source just captured
//   cur_src    index of the source being converted / displayed
//   bcd        six BCD digits, [3:0] least significant
//   bcd_valid  set once the first conversion has completed
//   busy       high while a conversion is in progress
//
// Optional feature macro: DISP_LEADING_BLANK_EN
//   When defined, leading zero digits (never digit 0) are written as 4'hF.
module disp_arbiter #(
    parameter int W     = 20,
    parameter int NREQ  = 4,
    parameter int DWELL = 2_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] val,
    output logic [NREQ-1:0]   grant,
    output logic [2:0]        cur_src,
    output logic [23:0]       bcd,
    output logic              bcd_valid,
    output logic              busy
);

    localparam int CW  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int IW  = $clog2(W + 1);
    localparam int SRW = 24 + W;

    typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

    state_t          state_q, state_d;
    logic [SRW-1:0]  sr_q, sr_d;       // {bcd digits, remaining binary}
    logic [IW-1:0]   iter_q, iter_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [23:0]     bcd_q, bcd_d;
    logic            vld_q, vld_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [2:0]      cur_q, cur_d;
    logic [2:0]      last_q, last_d;   // last granted source

    // Round-robin search starting one past the last grant.
    logic       found;
    logic [2:0] pick;
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        pick  = '0;
        for (int off = 1; off <= NREQ; off++) begin
            idx = (int'(last_q) + off) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = 3'(idx);
            end
        end
    end

    // Snapshot of the selected source, clamped to what six digits can show.
    logic [W-1:0] sel_val, cap_val;
    always_comb begin
        sel_val = val[int'(pick)*W +: W];
        if (32'(sel_val) > 32'd999999) cap_val = W'(32'd999999);
        else                           cap_val = sel_val;
    end

    // One shift-and-add-3 step.
    logic [23:0]    adj;
    logic [SRW-1:0] sr_nx;
    logic [23:0]    conv_bcd;
    always_comb begin
        logic [3:0] nib;
        logic       lead;
        nib  = '0;
        lead = 1'b0;
        for (int i = 0; i < 6; i++) begin
            nib = sr_q[W + 4*i +: 4];
            adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
        sr_nx    = {adj, sr_q[W-1:0]} << 1;
        conv_bcd = sr_nx[SRW-1 -: 24];
`ifdef DISP_LEADING_BLANK_EN
        lead = 1'b1;
        for (int i = 5; i >= 1; i--) begin
            if (lead && conv_bcd[4*i +: 4] == 4'd0) conv_bcd[4*i +: 4] = 4'hF;
            else                                   lead = 1'b0;
        end
`endif
    end

    always_comb begin
        logic cap;
        cap     = 1'b0;
        state_d = state_q;
        sr_d    = sr_q;
        iter_d  = iter_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        vld_d   = vld_q;
        grant_d = '0;
        cur_d   = cur_q;
        last_d  = last_q;
        case (state_q)
            IDLE: cap = found;
            CONV: begin
                sr_d   = sr_nx;
                iter_d = iter_q + IW'(1);
                if (iter_q == IW'(W - 1)) begin
                    bcd_d   = conv_bcd;
                    vld_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q == CW'(DWELL - 1)) begin
                    if (found) cap = 1'b1;
                    else       state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (cap) begin
            sr_d    = {24'd0, cap_val};
            iter_d  = '0;
            grant_d = {{(NREQ-1){1'b0}}, 1'b1} << pick;
            cur_d   = pick;
            last_d  = pick;
            state_d = CONV;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            iter_q  <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            vld_q   <= 1'b0;
            grant_q <= '0;
            cur_q   <= '0;
            last_q  <= 3'(NREQ - 1);  // first search then starts at 0
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            iter_q  <= iter_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            vld_q   <= vld_d;
            grant_q <= grant_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
        end
    end

    assign grant     = grant_q;
    assign cur_src   = cur_q;
    assign bcd       = bcd_q;
    assign bcd_valid = vld_q;
    assign busy      = (state_q == CONV);

endmodule

// File: tb/tb_disp_arbiter.sv
module tb_disp_arbiter;
    localparam int W = 20, NREQ = 4, DWELL = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] val;
    logic [NREQ-1:0]   grant;
    logic [2:0]        cur_src;
    logic [23:0]       bcd;
    logic              bcd_valid;
    logic              busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    disp_arbiter #(.W(W), .NREQ(NREQ), .DWELL(DWELL)) dut (
        .clk(clk), .rst(rst), .req(req), .val(val), .grant(grant),
        .cur_src(cur_src), .bcd(bcd), .bcd_valid(bcd_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: decimal digits of the saturated value.
    function automatic logic [23:0] ref_bcd(input int unsigned v);
        int unsigned s;
        logic [23:0] r;
        s = (v > 999999) ? 999999 : v;
        for (int i = 0; i < 6; i++) begin
            r[i*4 +: 4] = 4'(s % 10);
            s = s / 10;
        end
`ifdef DISP_LEADING_BLANK_EN
        begin
            bit lead;
            lead = 1'b1;
            for (int i = 5; i >= 1; i--) begin
                if (lead && r[i*4 +: 4] == 4'd0) r[i*4 +: 4] = 4'hF;
                else lead = 1'b0;
            end
        end
`endif
        return r;
    endfunction

    // Reference: first requester after 'last', wrapping.
    function automatic int rr_next(input int last, input logic [NREQ-1:0] r);
        for (int off = 1; off <= NREQ; off++)
            if (r[(last + off) % NREQ]) return (last + off) % NREQ;
        return -1;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int maxc, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < maxc) begin
            tick();
            cyc++;
            if (grant != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic rand_vals();
        for (int i = 0; i < NREQ; i++) val[i*W +: W] = W'($urandom_range(0, (1 << W) - 1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'($urandom_range(1, 15));
        rand_vals();
        tick(2);
        total_cnt++; if (grant !== 4'b0) $display("FAIL reset_grant got %b want 0000", grant); else pass_cnt++;
        total_cnt++; if (cur_src !== 3'd0) $display("FAIL reset_cur_src got %0d want 0", cur_src); else pass_cnt++;
        total_cnt++; if (bcd !== 24'h0) $display("FAIL reset_bcd got %h want 000000", bcd); else pass_cnt++;
        total_cnt++; if (bcd_valid !== 1'b0) $display("FAIL reset_bcd_valid got %b want 0", bcd_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        rst = 1'b0;
        req = '0;
    endtask

    task automatic test_single();
        int cyc; bit ok;
        do_reset();
        rand_vals();
        val[2*W +: W] = W'(123456);
        req = 4'b0100;
        wait_grant(5, cyc, ok);
        total_cnt++; if (!ok || cyc != 1) $display("FAIL single_latency got ok=%0d cyc=%0d want ok=1 cyc=1", ok, cyc); else pass_cnt++;
        total_cnt++; if (grant !== 4'b0100) $display("FAIL single_grant got %b want 0100", grant); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1 || cur_src !== 3'd2) $display("FAIL single_busy_src got busy=%b src=%0d want 1/2", busy, cur_src); else pass_cnt++;
        req = '0;
        tick(1);
        total_cnt++; if (grant !== 4'b0) $display("FAIL single_grant_pulse got %b want 0000", grant); else pass_cnt++;
        tick(W - 2);
        total_cnt++; if (bcd !== 24'h0 || busy !== 1'b1) $display("FAIL single_pre_done got bcd=%h busy=%b want 000000/1", bcd, busy); else pass_cnt++;
        tick(1);
        total_cnt++; if (bcd !== 24'h123456) $display("FAIL single_bcd got %h want 123456", bcd); else pass_cnt++;
        total_cnt++; if (bcd_valid !== 1'b1 || busy !== 1'b0 || cur_src !== 3'd2)
            $display("FAIL single_done got valid=%b busy=%b src=%0d want 1/0/2", bcd_valid, busy, cur_src); else pass_cnt++;
    endtask

    // Five turns with all requesters on, then turns with random request sets.
    task automatic test_round_robin();
        int cyc, expc, last, exp_src;
        bit ok;
        int unsigned snap;
        do_reset();
        rand_vals();
        req  = 4'b1111;
        last = NREQ - 1;
        expc = 1;
        for (int t = 0; t < 15; t++) begin
            exp_src = rr_next(last, req);
            wait_grant(W + DWELL + 4, cyc, ok);
            total_cnt++; if (!ok || cyc != expc) $display("FAIL rr_interval turn %0d got ok=%0d cyc=%0d want %0d", t, ok, cyc, expc); else pass_cnt++;
            total_cnt++; if (grant !== 4'(1 << exp_src) || cur_src !== 3'(exp_src))
                $display("FAIL rr_grant turn %0d got %b src=%0d want src %0d", t, grant, cur_src, exp_src); else pass_cnt++;
            snap = 32'(val[exp_src*W +: W]);
            last = exp_src;
            rand_vals();
            if (t >= 4) req = 4'($urandom_range(1, 15));
            tick(W);
            total_cnt++; if (bcd !== ref_bcd(snap) || bcd_valid !== 1'b1)
                $display("FAIL rr_bcd turn %0d got %h valid=%b want %h", t, bcd, bcd_valid, ref_bcd(snap)); else pass_cnt++;
            expc = DWELL;
        end
    endtask

    task automatic test_saturate();
        int cyc; bit ok;
        do_reset();
        rand_vals();
        val[1*W +: W] = W'(1048575);
        req = 4'b0010;
        wait_grant(5, cyc, ok);
        req = '0;
        tick(W);
        total_cnt++; if (!ok || bcd !== 24'h999999) $display("FAIL sat_max got ok=%0d bcd=%h want 999999", ok, bcd); else pass_cnt++;
        val[1*W +: W] = '0;
        req = 4'b0010;
        wait_grant(DWELL + 5, cyc, ok);
        req = '0;
        tick(W);
`ifdef DISP_LEADING_BLANK_EN
        total_cnt++; if (!ok || bcd !== 24'hFFFFF0) $display("FAIL sat_zero got ok=%0d bcd=%h want fffff0", ok, bcd); else pass_cnt++;
`else
        total_cnt++; if (!ok || bcd !== 24'h000000) $display("FAIL sat_zero got ok=%0d bcd=%h want 000000", ok, bcd); else pass_cnt++;
`endif
    endtask

    task automatic test_blank();
        int cyc; bit ok;
        do_reset();
        rand_vals();
        val[3*W +: W] = W'(42);
        req = 4'b1000;
        wait_grant(5, cyc, ok);
        req = '0;
        tick(W);
`ifdef DISP_LEADING_BLANK_EN
        total_cnt++; if (!ok || bcd !== 24'hFFFF42) $display("FAIL blank_42 got ok=%0d bcd=%h want ffff42", ok, bcd); else pass_cnt++;
`else
        total_cnt++; if (!ok || bcd !== 24'h000042) $display("FAIL blank_42 got ok=%0d bcd=%h want 000042", ok, bcd); else pass_cnt++;
`endif
    endtask

    task automatic test_ignore_midconv();
        int cyc; bit ok;
        int unsigned snap;
        do_reset();
        rand_vals();
        snap = 32'(val[0 +: W]);
        req = 4'b0001;
        wait_grant(5, cyc, ok);
        tick(10);
        val[0 +: W] = ~val[0 +: W];
        req = '0;
        tick(W - 10);
        total_cnt++; if (!ok || bcd !== ref_bcd(snap)) $display("FAIL mid_snap got ok=%0d bcd=%h want %h", ok, bcd, ref_bcd(snap)); else pass_cnt++;
        tick(DWELL + 3);
        total_cnt++; if (grant !== 4'b0 || busy !== 1'b0) $display("FAIL mid_idle got grant=%b busy=%b want 0000/0", grant, busy); else pass_cnt++;
        total_cnt++; if (bcd !== ref_bcd(snap) || bcd_valid !== 1'b1)
            $display("FAIL mid_hold_display got bcd=%h valid=%b want %h/1", bcd, bcd_valid, ref_bcd(snap)); else pass_cnt++;
        req = 4'b0100;
        wait_grant(4, cyc, ok);
        total_cnt++; if (!ok || cyc != 1 || grant !== 4'b0100)
            $display("FAIL idle_zero_wait got ok=%0d cyc=%0d grant=%b want 1/1/0100", ok, cyc, grant); else pass_cnt++;
        req = '0;
    endtask

    task automatic test_reset_midconv();
        int cyc; bit ok;
        do_reset();
        rand_vals();
        req = 4'b0100;
        wait_grant(5, cyc, ok);
        req = '0;
        tick(10);
        rst = 1'b1;
        tick(1);
        total_cnt++; if (grant !== 4'b0 || busy !== 1'b0 || cur_src !== 3'd0 || bcd !== 24'h0 || bcd_valid !== 1'b0)
            $display("FAIL rstmid_outputs got grant=%b busy=%b src=%0d bcd=%h valid=%b want all 0",
                     grant, busy, cur_src, bcd, bcd_valid); else pass_cnt++;
        rst = 1'b0;
        tick(W + 2);
        total_cnt++; if (bcd !== 24'h0 || bcd_valid !== 1'b0) $display("FAIL rstmid_no_update got bcd=%h valid=%b want 000000/0", bcd, bcd_valid); else pass_cnt++;
        req = 4'b1111;
        wait_grant(4, cyc, ok);
        total_cnt++; if (!ok || grant !== 4'b0001) $display("FAIL rstmid_first_grant got ok=%0d grant=%b want 0001", ok, grant); else pass_cnt++;
        req = '0;
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        val = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_saturate();
        test_blank();
        test_ignore_midconv();
        test_reset_midconv();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/disp_arbiter.md
# disp_arbiter

Time-shares the six-digit seven-segment display between up to NREQ value sources inside the CPU top level. For each round-robin turn it snapshots one source, converts the binary value to six BCD digits with a multicycle shift-and-add-3 sequence, and holds the result for a programmable dwell time. Its BCD output feeds the digit-scan and segment-decode stage, which is unchanged.

## Interface
- W, 20: width of each source value in bits (≤ 20).
- NREQ, 4: number of requesters (2..8).
- DWELL, 2_000_000: clock cycles a converted value is held before re-arbitration (≥ 1).
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-source display request; level-sensitive.
- val  in  NREQ*W  flat value bus; source i occupies bits [i*W +: W].
- grant  out  NREQ  one-hot, one-cycle pulse marking the source whose value was just captured.
- cur_src  out  3  index of the source currently converted or displayed.
- bcd  out  24  digits; [3:0] is the least-significant digit and [23:20] the most-significant.
- bcd_valid  out  1  high once the first conversion has completed.
- busy  out  1  high while a conversion is in progress.

## Operation
- States: IDLE, CONV, HOLD.
- IDLE: if any req bit is high, select a source, capture its val into the shift register, pulse grant, set cur_src, then go to CONV. Otherwise stay in IDLE.
- Selection is round-robin. Search starts at (last granted + 1) mod NREQ and wraps; the first set req bit wins. After reset the search starts at 0.
- Saturation: a captured value > 999999 is replaced by 999999 before conversion.
- CONV runs exactly W iterations. Each iteration adds 3 to every BCD nibble ≥ 5, then shifts the {bcd, bin} register left by 1. On the final iteration bcd is written, bcd_valid is set and the dwell counter is cleared; the state goes to HOLD.
- HOLD: bcd is held stable while the dwell counter counts to DWELL-1. At expiry, arbitrate as in IDLE: with any req, capture and go to CONV; with none, go to IDLE.
- A lone requester is re-captured every turn, so its displayed value refreshes once per DWELL+W cycles.
- bcd and bcd_valid keep their last values in IDLE and CONV. The display never blanks after the first conversion.
- req changes and val changes during CONV or HOLD are ignored. The snapshot is taken only at capture.
- Reset values: state IDLE, grant 0, cur_src 0, bcd 0, bcd_valid 0, busy 0, round-robin pointer such that the next search starts at 0, dwell counter 0.

## Timing
- Capture at edge k, when req is sampled high in IDLE or at HOLD expiry. grant and busy are high from edge k.
- grant falls at edge k+1.
- bcd and bcd_valid update at edge k+W. busy falls at edge k+W.
- bcd changes only at the edge that ends a conversion.
- HOLD lasts DWELL cycles: the next capture occurs at edge k+W+DWELL if any req is high.
- From IDLE, a request whose req rises before edge k is captured at edge k, with zero added wait.
- rst asserted in any state overrides everything at that edge. A conversion in progress is discarded and no grant is issued in that cycle.

## Configuration
- DISP_LEADING_BLANK_EN defined:
  - At the edge that writes bcd, each leading zero digit is replaced by 4'hF, the blank code for the segment decoder.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
- DISP_LEADING_BLANK_EN undefined: all six digits are shown, including leading zeros.

## Test plan
Bench settings: W=20, NREQ=4, DWELL=8, macro undefined unless stated.
- Reset, then req=4'b0100 with source 2 value 123456 → one grant=4'b0100 pulse; 20 cycles later bcd=24'h123456, bcd_valid=1, cur_src=2.
- req=4'b1111 held high → grant sequence 0,1,2,3,0, one grant every 28 cycles.
- Source 1 value 1048575 → bcd=24'h999999. Source 1 value 0 → bcd=24'h000000.
- val changed and req dropped mid-CONV → bcd equals the captured snapshot; the FSM returns to IDLE after HOLD, and bcd_valid stays 1.
- rst pulsed 10 cycles into CONV → outputs at reset values, no bcd update; a new request afterwards is granted to source 0 first.
- DISP_LEADING_BLANK_EN defined, value 42 → bcd=24'hFFFF42. Value 0 → bcd=24'hFFFFF0.
